// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its sequencing controller.
// The pipeline (master) reports hazard sources and the controller (slave) returns stage controls.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        memwb_en;
  logic        memwb_bubble;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           memwb_bubble, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           memwb_bubble, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, taken-branch and memory-wait hazards with
// Mealy stage controls, a memory-wait watchdog and a saturating freeze-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_stall_inc;

  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic w_exmem_en, w_memwb_en, w_memwb_bubble;
  logic w_mem_haz, w_load_use;

  assign w_mem_haz  = hz.mem_req & ~hz.mem_ready;
  assign w_load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

  // Next-state and Mealy stage controls; RUN and MEM_WAIT share the same decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = '0;
    w_timeout_nxt  = r_timeout;
    w_stall_inc    = 1'b0;
    w_pc_en        = 1'b0;
    w_ifid_en      = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_en      = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_en     = 1'b0;
    w_memwb_en     = 1'b0;
    w_memwb_bubble = 1'b0;

    if (rst_n) begin
      case (r_state)
        S_RUN, S_MEM_WAIT: begin
          if (w_mem_haz) begin
            w_memwb_en     = 1'b1;
            w_memwb_bubble = 1'b1;
            w_wait_nxt     = r_wait_cnt + WAIT_W'(1);
            w_state_nxt    = S_MEM_WAIT;
            if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
              w_timeout_nxt = 1'b1;
              w_state_nxt   = S_HALT;
            end
          end else begin
            w_state_nxt = S_RUN;
            w_pc_en     = 1'b1;
            w_ifid_en   = 1'b1;
            w_idex_en   = 1'b1;
            w_exmem_en  = 1'b1;
            w_memwb_en  = 1'b1;
            if (hz.branch_taken) begin
              w_ifid_flush = 1'b1;
              w_idex_flush = 1'b1;
            end else if (w_load_use) begin
              w_pc_en      = 1'b0;
              w_ifid_en    = 1'b0;
              w_idex_flush = 1'b1;
            end
          end
          w_stall_inc = ~w_pc_en;
        end
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.pc_en        = w_pc_en;
  assign hz.ifid_en      = w_ifid_en;
  assign hz.ifid_flush   = w_ifid_flush;
  assign hz.idex_en      = w_idex_en;
  assign hz.idex_flush   = w_idex_flush;
  assign hz.exmem_en     = w_exmem_en;
  assign hz.memwb_en     = w_memwb_en;
  assign hz.memwb_bubble = w_memwb_bubble;
  assign hz.mem_timeout  = r_timeout;
  assign hz.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed scoreboard bench for pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned WAIT_W   = 3;

  typedef struct {
    logic [7:0]  ctl;   // {pc,ifid_en,ifid_flush,idex_en,idex_flush,exmem,memwb_en,bubble}
    logic [7:0]  mask;
    logic        tmo;
    logic [15:0] stall;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: only what the rules need.
  bit          m_halted  = 1'b0;
  int          m_waits   = 0;
  bit          m_tmo     = 1'b0;
  int          m_stall   = 0;

  task automatic cycle(input bit rst, input int rs, input int rt, input bit mrd, input int ert,
                       input bit br, input bit req, input bit rdy, input string tag);
    exp_t e;
    bit   luse;
    bit   haz;
    @(posedge clk);
    #1;
    rst_n           = rst;
    hz.id_rs        = 5'(rs);
    hz.id_rt        = 5'(rt);
    hz.ex_mem_read  = mrd;
    hz.ex_rt        = 5'(ert);
    hz.branch_taken = br;
    hz.mem_req      = req;
    hz.mem_ready    = rdy;

    haz  = req && !rdy;
    luse = mrd && ert != 0 && (ert == rs || ert == rt);
    e.tag   = tag;
    e.mask  = 8'hFF;
    e.tmo   = m_tmo;
    e.stall = 16'(m_stall);
    if (!rst || m_halted)  e.ctl = 8'b0000_0000;
    else if (haz)          e.ctl = 8'b0000_0011;
    else if (br)           e.ctl = 8'b1111_1110;
    else if (luse) begin
      e.ctl  = 8'b0001_1110;
      e.mask = 8'b1110_1111;  // ID_EX enable is irrelevant while it is being flushed
    end
    else                   e.ctl = 8'b1101_0110;
    exp_q.push_back(e);

    if (!rst) begin
      m_halted = 0; m_waits = 0; m_tmo = 0; m_stall = 0;
    end else if (!m_halted) begin
      if (e.ctl[7] == 1'b0 && m_stall < 65535) m_stall++;
      if (haz) begin
        m_waits++;
        if (m_waits == int'(MAX_WAIT)) begin
          m_tmo = 1; m_halted = 1;
        end
      end else m_waits = 0;
    end
  endtask

  task automatic idle(input string tag);
    cycle(1, 1, 2, 0, 0, 0, 0, 0, tag);
  endtask

  // Monitor: every cycle presents Mealy controls; compare at the falling edge.
  initial begin
    exp_t e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        got = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
               hz.exmem_en, hz.memwb_en, hz.memwb_bubble};
        n_checks++;
        if ((got & e.mask) === (e.ctl & e.mask)) n_pass++;
        else $display("FAIL %s ctl: got %b exp %b (mask %b) t=%0t", e.tag, got, e.ctl, e.mask, $time);
        n_checks++;
        if (hz.mem_timeout === e.tmo) n_pass++;
        else $display("FAIL %s mem_timeout: got %b exp %b t=%0t", e.tag, hz.mem_timeout, e.tmo, $time);
        n_checks++;
        if (hz.stall_cnt === e.stall) n_pass++;
        else $display("FAIL %s stall_cnt: got %0d exp %0d t=%0t", e.tag, hz.stall_cnt, e.stall, $time);
      end
    end
  end

  initial begin
    int budget;
    hz.id_rs = '0; hz.id_rt = '0; hz.ex_mem_read = 1'b0; hz.ex_rt = '0;
    hz.branch_taken = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    cycle(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    cycle(0, 5, 5, 1, 5, 1, 1, 0, "reset_forced");
    idle("normal");

    // Load-use, then the same with ex_rt=0, then via rt.
    cycle(1, 5, 7, 1, 5, 0, 0, 0, "loaduse_rs");
    idle("after_loaduse");
    cycle(1, 0, 0, 1, 0, 0, 0, 0, "loaduse_r0");
    cycle(1, 3, 9, 1, 9, 0, 0, 0, "loaduse_rt");
    cycle(1, 3, 4, 1, 9, 0, 0, 1, "nomatch_rdy_noreq");

    // Memory wait 3 cycles, then ready.
    for (int i = 0; i < 3; i++) cycle(1, 1, 2, 0, 0, 0, 1, 0, "memwait");
    cycle(1, 1, 2, 0, 0, 0, 1, 1, "mem_done");
    idle("after_mem");

    // Branch with load-use match; branch during memory wait.
    cycle(1, 5, 5, 1, 5, 1, 0, 0, "branch_over_loaduse");
    cycle(1, 1, 2, 0, 0, 1, 1, 0, "branch_in_wait");
    cycle(1, 1, 2, 0, 0, 1, 1, 0, "branch_in_wait2");
    cycle(1, 1, 2, 0, 0, 1, 1, 1, "branch_after_wait");
    cycle(1, 1, 2, 0, 0, 0, 1, 0, "wait_then_reqdrop");
    cycle(1, 1, 2, 0, 0, 0, 0, 0, "reqdrop");

    // Watchdog: ready held low past the limit, then stays halted.
    for (int i = 0; i < 7; i++) cycle(1, 5, 5, 1, 5, 1, 1, 0, "watchdog");
    idle("halted_idle");

    // Reset recovers from HALT and from mid-wait.
    cycle(0, 1, 2, 0, 0, 0, 1, 0, "reset_from_halt");
    cycle(1, 1, 2, 0, 0, 0, 1, 0, "wait_a");
    cycle(1, 1, 2, 0, 0, 0, 1, 0, "wait_b");
    cycle(0, 1, 2, 0, 0, 0, 1, 0, "reset_midwait");
    idle("after_reset");

    // Random mix with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 39) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) >= 2, "random");
    end

    // Saturation of the freeze counter.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "sat_reset");
    for (int i = 0; i < 70000; i++) cycle(1, 6, 1, 1, 6, 0, 0, 0, "saturate");
    idle("saturated");
    idle("saturated2");

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
